// File: rtl/pid_pkg.sv
// Shared definitions for the pipelined balance PID controller.
//  - I_SHIFT and soft-start increment choices for fast-simulation and
//    silicon builds
//  - sat_signed(): clamp a signed value into a given two's-complement width
//  - tmr_t: the 27-bit soft-start timer type
package pid_pkg;

  localparam int I_SHIFT_FAST = 1;
  localparam int I_SHIFT_SLOW = 6;
  localparam int SS_INC_FAST  = 256;
  localparam int SS_INC_SLOW  = 1;

  localparam int TMR_W = 27;
  typedef logic [TMR_W-1:0] tmr_t;

  // Clamp value to [-2^(width-1), 2^(width-1)-1]. The result is still 64 bits
  // wide; the caller truncates it to width bits, which is then lossless.
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value,
                                                    input int width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (value > hi)      return hi;
    else if (value < lo) return lo;
    else                 return value;
  endfunction

endpackage

// File: rtl/pid_sat.sv
// Combinational signed saturator.
//  din   in   IN_W   signed value to clamp
//  dout  out  OUT_W  din clamped to the OUT_W signed range
module pid_sat
  import pid_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 10
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout
);

  logic signed [63:0] wide;

  assign wide = 64'(din);
  assign dout = OUT_W'(sat_signed(wide, OUT_W));

endmodule

// File: rtl/pid_cntrl_pipe.sv
// Three-stage pipelined pitch PID controller for the balance loop.
//  clk        in   1      clock
//  rst_n      in   1      asynchronous active-low reset
//  vld        in   1      new ptch/ptch_rt sample this cycle
//  ptch       in   IN_W   signed pitch
//  ptch_rt    in   IN_W   signed pitch rate
//  pwr_up     in   1      0 clears the soft-start timer
//  rider_off  in   1      clears the integrator and drops in-flight samples
//  int_hold   in   1      freezes the integrator; P/D paths keep updating
//  PID_cntrl  out  OUT_W  saturated control word, held between strobes
//  PID_vld    out  1      pulse: PID_cntrl updated this cycle (3 cycles after vld)
//  int_clip   out  1      pulse: the last integrator update saturated
//  ss_tmr     out  8      soft-start ramp, timer bits [26:19]
module pid_cntrl_pipe
  import pid_pkg::*;
#(
  parameter int FAST_SIM = 1,
  parameter int IN_W     = 16,
  parameter int ERR_W    = 10,
  parameter int INT_W    = 18,
  parameter int OUT_W    = 12,
  parameter int P_COEFF  = 12,
  parameter int D_SHIFT  = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    vld,
  input  logic signed [IN_W-1:0]  ptch,
  input  logic signed [IN_W-1:0]  ptch_rt,
  input  logic                    pwr_up,
  input  logic                    rider_off,
  input  logic                    int_hold,
  output logic signed [OUT_W-1:0] PID_cntrl,
  output logic                    PID_vld,
  output logic                    int_clip,
  output logic [7:0]              ss_tmr
);

  localparam int I_SHIFT = (FAST_SIM != 0) ? I_SHIFT_FAST : I_SHIFT_SLOW;
  localparam int SS_INC  = (FAST_SIM != 0) ? SS_INC_FAST : SS_INC_SLOW;
  localparam int P_W     = ERR_W + 6;
  // One extra bit so negating the most negative shifted rate is exact.
  localparam int D_W     = IN_W + 1;
  localparam int SUM_W   = INT_W + 2;

  localparam logic signed [P_W-1:0] P_K = P_W'(P_COEFF);

  logic signed [ERR_W-1:0] err;
  logic signed [INT_W:0]   integ_sum;
  logic signed [INT_W-1:0] integ_sat;
  logic                    integ_ovf;

  logic signed [ERR_W-1:0] err_s1;
  logic signed [IN_W-1:0]  rt_s1;
  logic                    v1;
  logic signed [INT_W-1:0] integ;

  logic signed [P_W-1:0]   p_term;
  logic signed [INT_W-1:0] i_term;
  logic signed [D_W-1:0]   d_term;
  logic signed [P_W-1:0]   p_s2;
  logic signed [INT_W-1:0] i_s2;
  logic signed [D_W-1:0]   d_s2;
  logic                    v2;

  logic signed [SUM_W-1:0] sum;
  logic signed [OUT_W-1:0] sum_sat;

  tmr_t tmr;

  pid_sat #(.IN_W(IN_W), .OUT_W(ERR_W)) u_err_sat (
    .din  (ptch),
    .dout (err)
  );

  // One extra bit holds any integ+err sum; the top two bits disagreeing
  // means the result does not fit back into INT_W.
  assign integ_sum = (INT_W+1)'(integ) + (INT_W+1)'(err);
  assign integ_ovf = integ_sum[INT_W] ^ integ_sum[INT_W-1];

  pid_sat #(.IN_W(INT_W+1), .OUT_W(INT_W)) u_int_sat (
    .din  (integ_sum),
    .dout (integ_sat)
  );

  // ---- stage 1: capture error/rate, update integrator ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_s1   <= '0;
      rt_s1    <= '0;
      v1       <= 1'b0;
      integ    <= '0;
      int_clip <= 1'b0;
    end else begin
      v1       <= vld & ~rider_off;
      int_clip <= vld & ~rider_off & ~int_hold & integ_ovf;
      if (vld) begin
        err_s1 <= err;
        rt_s1  <= ptch_rt;
      end
      if (rider_off)
        integ <= '0;
      else if (vld && !int_hold)
        integ <= integ_sat;
    end
  end

  assign p_term = P_W'(err_s1) * P_K;
  // integ already holds this sample's update (or the held value).
  assign i_term = integ >>> I_SHIFT;
  assign d_term = -(D_W'(rt_s1) >>> D_SHIFT);

  // ---- stage 2: P, I and D terms ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_s2 <= '0;
      i_s2 <= '0;
      d_s2 <= '0;
      v2   <= 1'b0;
    end else begin
      v2 <= v1 & ~rider_off;
      if (v1) begin
        p_s2 <= p_term;
        i_s2 <= i_term;
        d_s2 <= d_term;
      end
    end
  end

  // Full-width sum; the only saturation is on the final word.
  assign sum = SUM_W'(p_s2) + SUM_W'(i_s2) + SUM_W'(d_s2);

  pid_sat #(.IN_W(SUM_W), .OUT_W(OUT_W)) u_out_sat (
    .din  (sum),
    .dout (sum_sat)
  );

  // ---- stage 3: saturated output and strobe ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      PID_cntrl <= '0;
      PID_vld   <= 1'b0;
    end else begin
      PID_vld <= v2 & ~rider_off;
      if (rider_off)
        PID_cntrl <= '0;
      else if (v2)
        PID_cntrl <= sum_sat;
    end
  end

  // Soft-start ramp: climbs until bits [26:8] are all ones, then parks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      tmr <= '0;
    else if (!pwr_up)
      tmr <= '0;
    else if (~&tmr[TMR_W-1:8])
      tmr <= tmr + TMR_W'(SS_INC);
  end

  assign ss_tmr = tmr[TMR_W-1 -: 8];

endmodule

// File: tb/tb_pid_cntrl_pipe.sv
// Self-checking bench for pid_cntrl_pipe. Two instances (FAST_SIM=1 and 0)
// share one stimulus stream; a behavioural model predicts both.
module tb_pid_cntrl_pipe;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               vld;
  logic signed [15:0] ptch;
  logic signed [15:0] ptch_rt;
  logic               pwr_up;
  logic               rider_off;
  logic               int_hold;

  logic signed [11:0] out_f, out_s;
  logic               pvld_f, pvld_s;
  logic               clip_f, clip_s;
  logic [7:0]         ss_f, ss_s;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  pid_cntrl_pipe #(.FAST_SIM(1)) dut_f (
    .clk(clk), .rst_n(rst_n), .vld(vld), .ptch(ptch), .ptch_rt(ptch_rt),
    .pwr_up(pwr_up), .rider_off(rider_off), .int_hold(int_hold),
    .PID_cntrl(out_f), .PID_vld(pvld_f), .int_clip(clip_f), .ss_tmr(ss_f)
  );

  pid_cntrl_pipe #(.FAST_SIM(0)) dut_s (
    .clk(clk), .rst_n(rst_n), .vld(vld), .ptch(ptch), .ptch_rt(ptch_rt),
    .pwr_up(pwr_up), .rider_off(rider_off), .int_hold(int_hold),
    .PID_cntrl(out_s), .PID_vld(pvld_s), .int_clip(clip_s), .ss_tmr(ss_s)
  );

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int clamp(input int v, input int lo, input int hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // ------------------------------------------------------------------
  // Behavioural model: each accepted sample is turned straight into its
  // final output value and scheduled for the cycle three cycles later.
  // ------------------------------------------------------------------
  typedef struct {
    longint due;
    int     of;
    int     os;
  } exp_t;

  exp_t   pend[$];
  longint mcyc = 0;
  int     m_integ = 0;
  int     m_out_f = 0, m_out_s = 0;
  bit     m_vld = 0, m_clip = 0;
  longint m_tmr_f = 0, m_tmr_s = 0;

  always @(posedge clk) begin
    int   e, nx, d, pterm;
    exp_t x;
    if (!rst_n) begin
      pend.delete();
      m_integ = 0; m_out_f = 0; m_out_s = 0;
      m_vld = 0; m_clip = 0; m_tmr_f = 0; m_tmr_s = 0;
    end else begin
      m_vld  = 0;
      m_clip = 0;
      if (pend.size() > 0 && pend[0].due == mcyc + 1) begin
        x = pend.pop_front();
        m_vld = 1; m_out_f = x.of; m_out_s = x.os;
      end
      if (rider_off) begin
        pend.delete();
        m_vld = 0; m_out_f = 0; m_out_s = 0; m_integ = 0;
      end else if (vld) begin
        e = clamp(int'(ptch), -512, 511);
        if (!int_hold) begin
          nx = m_integ + e;
          if (nx > 131071 || nx < -131072) m_clip = 1;
          m_integ = clamp(nx, -131072, 131071);
        end
        d = -(int'(ptch_rt) >>> 6);
        pterm = e * 12;
        x.due = mcyc + 3;
        x.of = clamp(pterm + (m_integ >>> 1) + d, -2048, 2047);
        x.os = clamp(pterm + (m_integ >>> 6) + d, -2048, 2047);
        pend.push_back(x);
      end
      if (!pwr_up) begin
        m_tmr_f = 0; m_tmr_s = 0;
      end else begin
        if ((m_tmr_f >> 8) != 524287) m_tmr_f += 256;
        if ((m_tmr_s >> 8) != 524287) m_tmr_s += 1;
      end
    end
    mcyc++;
  end

  // Compare process: every cycle, all outputs of both instances.
  always @(negedge clk) begin
    if (rst_n && cmp_en) begin
      chk("cmp_vld_f",  pvld_f, m_vld);
      chk("cmp_vld_s",  pvld_s, m_vld);
      chk("cmp_out_f",  out_f, m_out_f);
      chk("cmp_out_s",  out_s, m_out_s);
      chk("cmp_clip_f", clip_f, m_clip);
      chk("cmp_clip_s", clip_s, m_clip);
      chk("cmp_ss_f",   ss_f, (m_tmr_f >> 19) & 255);
      chk("cmp_ss_s",   ss_s, (m_tmr_s >> 19) & 255);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rider();
    vld = 0; rider_off = 1; step(); rider_off = 0;
  endtask

  // One isolated sample, then check the strobe three cycles later.
  task automatic one_sample(input string nm, input logic signed [15:0] p,
                            input logic signed [15:0] r, input int ef, input int es);
    ptch = p; ptch_rt = r; vld = 1;
    step();
    vld = 0;
    step();
    chk({nm, "_early_vld"}, pvld_f, 0);
    step();
    chk({nm, "_vld_f"}, pvld_f, 1);
    chk({nm, "_vld_s"}, pvld_s, 1);
    chk({nm, "_out_f"}, out_f, ef);
    chk({nm, "_out_s"}, out_s, es);
  endtask

  initial begin
    rst_n = 0; vld = 0; ptch = 0; ptch_rt = 0;
    pwr_up = 0; rider_off = 0; int_hold = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_f", out_f, 0);
    chk("rst_vld_f", pvld_f, 0);
    chk("rst_clip_f", clip_f, 0);
    chk("rst_ss_f", ss_f, 0);
    chk("rst_out_s", out_s, 0);
    rst_n = 1; pwr_up = 1;
    cmp_en = 1;

    // P=192, integ=16 -> I=8 (fast) or 0 (slow)
    one_sample("t1", 16'sh0010, 16'sh0000, 200, 192);

    clear_rider();
    one_sample("t2_pos", 16'sh7000, 16'sh0000, 2047, 2047);
    one_sample("t2_neg", -16'sh8000, 16'sh0000, -2048, -2048);
    clear_rider();
    one_sample("t2_rt", 16'sh0000, 16'sh0400, -16, -16);

    // Integrator runs into its positive limit on the 257th sample.
    clear_rider();
    for (int i = 1; i <= 260; i++) begin
      ptch = 16'sh7000; ptch_rt = 0; vld = 1;
      step();
      chk("t3_clip", clip_f, (i >= 257) ? 1 : 0);
    end
    vld = 0;
    repeat (4) step();

    // Four back-to-back samples -> four back-to-back strobes.
    clear_rider();
    for (int k = 0; k < 8; k++) begin
      vld = (k < 4); ptch = 16'sh0032;
      step();
      chk("t4_b2b_vld", pvld_f, (k >= 2 && k <= 5) ? 1 : 0);
    end

    // rider_off between samples 2 and 3 drops everything in flight.
    vld = 0;
    for (int k = 0; k < 10; k++) begin
      vld = (k < 4);
      rider_off = (k == 2 || k == 3);
      ptch = 16'sh0032;
      step();
      chk("t4_ro_vld", pvld_f, 0);
    end
    chk("t4_ro_out", out_f, 0);
    one_sample("t4_integ0", 16'sh0000, 16'sh0000, 0, 0);

    // int_hold: integ stays at 16 while ptch=100 samples stream through.
    clear_rider();
    for (int k = 0; k < 7; k++) begin
      vld = (k < 4);
      ptch = (k == 0) ? 16'sh0010 : 16'sh0064;
      int_hold = (k >= 1 && k < 4);
      step();
      if (k == 2) begin
        chk("t5_first_f", out_f, 200);
      end else if (k >= 3 && k <= 5) begin
        chk("t5_hold_vld", pvld_f, 1);
        chk("t5_hold_f", out_f, 1208);
        chk("t5_hold_s", out_s, 1200);
      end
    end
    int_hold = 0; vld = 0;

    // Randomised traffic checked by the compare process.
    for (int n = 0; n < 2500; n++) begin
      vld = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0: ptch = 16'($urandom);
        1: ptch = 16'(int'($urandom_range(0, 1200)) - 600);
        2: ptch = $urandom_range(0, 1) ? 16'sh7FFF : -16'sh8000;
        default: ptch = 16'(int'($urandom_range(0, 40)) - 20);
      endcase
      ptch_rt   = 16'($urandom);
      int_hold  = ($urandom_range(0, 7) == 0);
      rider_off = ($urandom_range(0, 59) == 0);
      pwr_up    = ($urandom_range(0, 39) != 0);
      step();
    end
    vld = 0; int_hold = 0; rider_off = 0;

    // Soft-start ramp: ss_tmr bit 0 (timer bit 19) every 2048 clks in fast mode.
    pwr_up = 0;
    step();
    chk("t6_clr_f", ss_f, 0);
    chk("t6_clr_s", ss_s, 0);
    pwr_up = 1;
    repeat (2047) step();
    chk("t6_2047", ss_f, 0);
    step();
    chk("t6_2048", ss_f, 1);
    repeat (2048) step();
    chk("t6_4096_f", ss_f, 2);
    chk("t6_4096_s", ss_s, 0);
    pwr_up = 0;
    step();
    chk("t6_off", ss_f, 0);

    step();
    cmp_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
